// File: rtl/dmem_responder.sv
// Data-bus responder: 512-word RAM plus a peripheral page (GPIO, compare timer, TX FIFO).
// Reads are combinational from daddr; all writes land on the rising edge of CLK.
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GPIO_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [9:0]        daddr,
  input  logic [31:0]       ddata_w,
  input  logic              d_rw,
  output logic [31:0]       ddata_r,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int unsigned RamAw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [2:0] {
    RegGpioOut = 3'd0,
    RegGpioIn  = 3'd1,
    RegTmrCnt  = 3'd2,
    RegTmrCmp  = 3'd3,
    RegStatus  = 3'd4,
    RegTxPush  = 3'd5,
    RegCtrl    = 3'd6,
    RegRsvd    = 3'd7
  } reg_e;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       fifo_q [FIFO_DEPTH];

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              tmr_en_q, tmr_en_d;
  logic              irq_en_q, irq_en_d;
  logic              match_q, match_d;
  logic              ovf_q, ovf_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic ram_hit, periph, wr_reg, wr_ram;
  logic full, empty, pop, push_req, push, match;
  reg_e reg_sel;

  // Indices past the end of a short RAM read 0 and ignore writes.
  if (RAM_WORDS < 512) begin : g_ram_partial
    assign ram_hit = {1'b0, daddr[8:0]} < 10'(RAM_WORDS);
  end else begin : g_ram_full
    assign ram_hit = 1'b1;
  end

  assign periph   = daddr[9];
  assign reg_sel  = reg_e'(daddr[2:0]);
  assign wr_reg   = d_rw & periph;
  assign wr_ram   = d_rw & ~periph & ram_hit;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = ~empty & tx_ready;
  assign push_req = wr_reg & (reg_sel == RegTxPush);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign match    = tmr_en_q & (cnt_q == cmp_q);

  always_comb begin
    gpio_out_d = gpio_out_q;
    cnt_d      = cnt_q;
    cmp_d      = cmp_q;
    tmr_en_d   = tmr_en_q;
    irq_en_d   = irq_en_q;
    match_d    = match_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (tmr_en_q) cnt_d = match ? '0 : cnt_q + 32'd1;

    if (wr_reg) begin
      unique case (reg_sel)
        RegGpioOut: gpio_out_d = ddata_w[GPIO_W-1:0];
        RegTmrCnt:  cnt_d = ddata_w;
        RegTmrCmp:  cmp_d = ddata_w;
        RegStatus: begin
          if (ddata_w[0]) match_d = 1'b0;
          if (ddata_w[3]) ovf_d = 1'b0;
        end
        RegCtrl: begin
          tmr_en_d = ddata_w[0];
          irq_en_d = ddata_w[1];
        end
        default: ;
      endcase
    end

    // Sets are applied after the W1C so a coincident event is not lost.
    if (match) match_d = 1'b1;
    if (push_req & full & ~pop) ovf_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      cmp_q      <= '0;
      tmr_en_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      tmr_en_q   <= tmr_en_d;
      irq_en_q   <= irq_en_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= ddata_w;
  end

  always_ff @(posedge CLK) begin
    if (wr_ram) ram_q[daddr[RamAw-1:0]] <= ddata_w;
  end

  always_comb begin
    ddata_r = '0;
    if (!periph) begin
      if (ram_hit) ddata_r = ram_q[daddr[RamAw-1:0]];
    end else begin
      unique case (reg_sel)
        RegGpioOut: ddata_r = 32'(gpio_out_q);
        RegGpioIn:  ddata_r = 32'(sync2_q);
        RegTmrCnt:  ddata_r = cnt_q;
        RegTmrCmp:  ddata_r = cmp_q;
        RegStatus:  ddata_r = 32'({5'(count_q), ovf_q, empty, full, match_q});
        RegCtrl:    ddata_r = {30'd0, irq_en_q, tmr_en_q};
        default:    ddata_r = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign tx_valid = ~empty;
  assign tx_data  = empty ? '0 : fifo_q[rd_ptr_q];
  assign irq      = match_q & irq_en_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed literal checks plus randomized bus traffic compared
// every cycle against a queue/array model of the memory map.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic [31:0] ddata_r;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  always #5 CLK = ~CLK;

  dmem_responder #(
    .RAM_WORDS (512),
    .FIFO_DEPTH(4),
    .GPIO_W    (8)
  ) u_dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .daddr   (daddr),
    .ddata_w (ddata_w),
    .d_rw    (d_rw),
    .ddata_r (ddata_r),
    .gpio_out(gpio_out),
    .gpio_in (gpio_in),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .irq     (irq)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [31:0] m_ram [512];
  bit          m_known [512];
  logic [31:0] m_fifo [$];
  logic [7:0]  m_gin_hist [$];
  logic [31:0] m_cnt = '0, m_cmp = '0;
  logic [7:0]  m_gpio_out = '0;
  bit          m_tmr_en = 0, m_irq_en = 0, m_flag = 0, m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_rd_known(input logic [9:0] a);
    return a[9] || m_known[a[8:0]];
  endfunction

  function automatic logic [31:0] m_rd(input logic [9:0] a);
    if (!a[9]) return m_ram[a[8:0]];
    case (a[2:0])
      3'd0: return {24'd0, m_gpio_out};
      3'd1: return (m_gin_hist.size() == 2) ? {24'd0, m_gin_hist[0]} : 32'd0;
      3'd2: return m_cnt;
      3'd3: return m_cmp;
      3'd4: return {23'd0, 5'(m_fifo.size()), m_ovf, m_fifo.size() == 0,
                    m_fifo.size() == 4, m_flag};
      3'd6: return {30'd0, m_irq_en, m_tmr_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_gin_hist.delete();
    m_cnt = '0; m_cmp = '0; m_gpio_out = '0;
    m_tmr_en = 0; m_irq_en = 0; m_flag = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit pop, match, push_req;
    logic [31:0] cnt_n;
    pop      = (m_fifo.size() != 0) && tx_ready;
    push_req = d_rw && daddr[9] && (daddr[2:0] == 3'd5);
    match    = m_tmr_en && (m_cnt == m_cmp);
    cnt_n    = m_cnt;
    if (m_tmr_en) cnt_n = match ? 32'd0 : m_cnt + 32'd1;
    if (d_rw && daddr[9]) begin
      case (daddr[2:0])
        3'd0: m_gpio_out = ddata_w[7:0];
        3'd2: cnt_n = ddata_w;
        3'd3: m_cmp = ddata_w;
        3'd4: begin
          if (ddata_w[0]) m_flag = 0;
          if (ddata_w[3]) m_ovf = 0;
        end
        3'd6: begin
          m_tmr_en = ddata_w[0];
          m_irq_en = ddata_w[1];
        end
        default: ;
      endcase
    end
    if (d_rw && !daddr[9]) begin
      m_ram[daddr[8:0]] = ddata_w;
      m_known[daddr[8:0]] = 1;
    end
    m_cnt = cnt_n;
    if (match) m_flag = 1;
    if (pop) void'(m_fifo.pop_front());
    if (push_req) begin
      if (m_fifo.size() < 4) m_fifo.push_back(ddata_w);
      else m_ovf = 1;
    end
    m_gin_hist.push_back(gpio_in);
    if (m_gin_hist.size() > 2) void'(m_gin_hist.pop_front());
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) model_reset();
    else model_edge();
  end

  // Per-cycle comparison, mid low phase, after inputs for the cycle have settled.
  always @(negedge CLK) begin
    #1;
    if (chk_en) begin
      if (m_rd_known(daddr)) chk("ddata_r", ddata_r, m_rd(daddr));
      chk("gpio_out", 32'(gpio_out), 32'(m_gpio_out));
      chk("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
      chk("tx_data", tx_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
      chk("irq", 32'(irq), 32'(m_flag && m_irq_en));
    end
  end

  task automatic cyc(input bit rw, input logic [9:0] a, input logic [31:0] wd, input bit rdy);
    @(negedge CLK);
    d_rw = rw; daddr = a; ddata_w = wd; tx_ready = rdy;
    #2;
  endtask

  bit          r_rw;
  logic [9:0]  r_a;
  logic [31:0] r_wd;

  initial begin
    d_rw = 0; daddr = '0; ddata_w = '0; tx_ready = 0; gpio_in = '0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    chk_en  = 1'b1;

    cyc(0, 10'h204, 0, 0);
    chk("rst_status", ddata_r, 32'h4);

    // RAM
    cyc(1, 10'h005, 32'hDEADBEEF, 0);
    cyc(0, 10'h005, 0, 0);
    chk("ram_5", ddata_r, 32'hDEADBEEF);
    cyc(1, 10'h005, 32'h0BADF00D, 0);
    chk("ram_collide_old", ddata_r, 32'hDEADBEEF);
    cyc(1, 10'h1FF, 32'h12345678, 0);
    cyc(0, 10'h1FF, 0, 0);
    chk("ram_1ff", ddata_r, 32'h12345678);

    // Timer
    cyc(1, 10'h203, 32'd3, 0);
    cyc(1, 10'h206, 32'd1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 10'h202, 0, 0);
      chk("tmr_cnt_seq", ddata_r, (i < 4) ? 32'(i) : 32'd0);
    end
    cyc(0, 10'h204, 0, 0);
    chk("tmr_flag", ddata_r & 32'h1, 32'h1);
    cyc(1, 10'h206, 32'd3, 0);
    cyc(0, 10'h200, 0, 0);
    chk("irq_set", 32'(irq), 32'd1);
    cyc(1, 10'h206, 32'd2, 0);
    cyc(1, 10'h204, 32'd1, 0);
    cyc(0, 10'h204, 0, 0);
    chk("irq_w1c", 32'(irq), 32'd0);
    chk("flag_w1c", ddata_r & 32'h1, 32'h0);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 4; i++) cyc(1, 10'h205, 32'hC0DE0000 + 32'(i), 0);
    cyc(0, 10'h204, 0, 0);
    chk("fifo_full", ddata_r & 32'h1FE, 32'h42);
    cyc(1, 10'h205, 32'hC0DE0004, 0);
    cyc(0, 10'h204, 0, 0);
    chk("fifo_ovf", ddata_r & 32'h1FE, 32'h4A);
    chk("fifo_head_hold", tx_data, 32'hC0DE0000);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 10'h205, 0, 1);
      chk("fifo_drain", tx_data, 32'hC0DE0000 + 32'(i));
    end
    cyc(0, 10'h204, 0, 0);
    chk("fifo_empty_valid", 32'(tx_valid), 32'd0);
    chk("fifo_empty_status", ddata_r & 32'h1FE, 32'h0C);
    cyc(1, 10'h204, 32'h8, 0);
    cyc(0, 10'h204, 0, 0);
    chk("ovf_w1c", ddata_r & 32'h1FE, 32'h04);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1, 10'h205, 32'h100 + 32'(i), 0);
    cyc(1, 10'h205, 32'h1E, 1);
    chk("pp_pop_head", tx_data, 32'h100);
    cyc(0, 10'h204, 0, 0);
    chk("pp_count", ddata_r & 32'h1FE, 32'h42);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 10'h204, 0, 1);
      chk("pp_drain", tx_data, (i < 3) ? 32'h101 + 32'(i) : 32'h1E);
    end
    cyc(0, 10'h204, 0, 0);
    chk("pp_end", ddata_r & 32'h1FE, 32'h04);

    // GPIO
    cyc(1, 10'h200, 32'hA5, 0);
    cyc(0, 10'h201, 0, 0);
    chk("gpio_out", 32'(gpio_out), 32'hA5);
    gpio_in = 8'h5A;
    cyc(0, 10'h201, 0, 0);
    chk("gpio_in_1edge", ddata_r, 32'h0);
    cyc(0, 10'h239, 0, 0);
    chk("gpio_in_2edge_alias", ddata_r, 32'h5A);

    // Asynchronous reset mid-run
    cyc(1, 10'h202, 32'd5, 0);
    cyc(1, 10'h203, 32'd5, 0);
    cyc(1, 10'h206, 32'd3, 0);
    cyc(1, 10'h205, 32'h77, 0);
    cyc(0, 10'h200, 0, 0);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    cyc(0, 10'h206, 0, 0);
    chk("rst_ctrl", ddata_r, 32'd0);
    cyc(0, 10'h202, 0, 0);
    chk("rst_tmr_stopped", ddata_r, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) < 4)
        r_a = {1'b0, ($urandom_range(0, 1) != 0 ? 9'h1F0 : 9'h000) | 9'($urandom_range(0, 15))};
      else
        r_a = {1'b1, 6'($urandom), 3'($urandom_range(0, 7))};
      r_rw = ($urandom_range(0, 99) < 45);
      r_wd = $urandom;
      if (r_a[9] && (r_a[2:0] == 3'd2 || r_a[2:0] == 3'd3)) r_wd = 32'($urandom_range(0, 12));
      cyc(r_rw, r_a, r_wd, $urandom_range(0, 1) != 0);
      if ($urandom_range(0, 15) == 0) gpio_in = 8'($urandom);
      if (n == 700) begin
        #1 RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
      end
    end

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
